math_polar2rect_16: RTL and testbench

MATH_POLAR2RECT_16 -- requirements
Module: math_polar2rect_16

---
 rtl/math_pkg.sv | 43 ++++
 rtl/math_cordic_atan_rom.sv | 11 +
 rtl/math_polar2rect_16.sv | 161 ++++++++++++++++
 tb/tb_math_polar2rect_16.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/math_pkg.sv
// Shared constants, CORDIC arctangent table and FSM state type for math_polar2rect_16.
// The MATH_POLAR2RECT_GAIN_COMP_EN macro selects the x/y datapath width.
package math_pkg;

  localparam int DATA_W      = 16;
  localparam int MAG_W       = 17;
  localparam int PHASE_W     = 16;
  localparam int COEF_W      = 16;
  localparam int INV_K_FRAC  = 15;
  localparam int CORDIC_ITER = 16;
  localparam int ITER_W      = $clog2(CORDIC_ITER);
  localparam int GUARD_BITS  = 3;
  localparam int Z_W         = PHASE_W + 1;

  // Without gain compensation the result grows by K ~ 1.647, so x/y need one more bit.
`ifdef MATH_POLAR2RECT_GAIN_COMP_EN
  localparam int XY_W = MAG_W + GUARD_BITS + 1;
`else
  localparam int XY_W = MAG_W + GUARD_BITS + 2;
`endif

  localparam logic [COEF_W-1:0]  INV_K      = 16'd19898;
  localparam logic [1:0]         QUAD_90    = 2'b01;
  localparam logic [1:0]         QUAD_180   = 2'b10;
  localparam logic [PHASE_W-1:0] PHASE_HALF = 16'h8000;
  localparam int                 SAT_LIM    = 32767;

  // atan(2^-i) in phase units (0x10000 = full turn).
  localparam logic [PHASE_W-1:0] ATAN_TABLE [CORDIC_ITER] = '{
    16'd8192, 16'd4836, 16'd2555, 16'd1297,
    16'd651,  16'd326,  16'd163,  16'd81,
    16'd41,   16'd20,   16'd10,   16'd5,
    16'd3,    16'd1,    16'd1,    16'd0
  };

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PRESCALE = 2'd1,
    ROTATE   = 2'd2,
    DONE     = 2'd3
  } state_e;

endpackage

// File: rtl/math_cordic_atan_rom.sv
// Combinational lookup of the CORDIC arctangent constant for one iteration index.
module math_cordic_atan_rom
  import math_pkg::*;
(
  input  logic [ITER_W-1:0]  idx_i,
  output logic [PHASE_W-1:0] atan_o
);

  assign atan_o = ATAN_TABLE[idx_i];

endmodule

// File: rtl/math_polar2rect_16.sv
// Iterative rotation-mode CORDIC polar-to-rectangular converter, one iteration per enabled cycle.
// Define MATH_POLAR2RECT_GAIN_COMP_EN to add the PRESCALE state that removes the CORDIC gain.
module math_polar2rect_16
  import math_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ena,
  input  logic [MAG_W-1:0]          din_mag,
  input  logic [PHASE_W-1:0]        din_phase,
  input  logic                      din_valid,
  output logic                      din_ready,
  output logic signed [DATA_W-1:0]  dout_re,
  output logic signed [DATA_W-1:0]  dout_im,
  output logic                      dout_valid,
  input  logic                      dout_ready
);

  state_e                    state_q, state_d;
  logic [ITER_W-1:0]         iter_q, iter_d;
  logic signed [XY_W-1:0]    x_q, x_d, y_q, y_d;
  logic signed [Z_W-1:0]     z_q, z_d;
  logic signed [DATA_W-1:0]  re_q, re_d, im_q, im_d;
  logic                      vld_q, vld_d;

  logic                      fold;
  logic [PHASE_W-1:0]        ph_res;
  logic signed [XY_W-1:0]    pre_x;
  logic [PHASE_W-1:0]        atan_val;
  logic                      d_pos;
  logic signed [XY_W-1:0]    x_sh, y_sh, x_rot, y_rot;
  logic signed [Z_W-1:0]     z_rot;

  function automatic logic signed [DATA_W-1:0] round_sat(input logic signed [XY_W-1:0] v);
    int t;
    t = (int'(v) + (1 <<< (GUARD_BITS - 1))) >>> GUARD_BITS;
    if (t > SAT_LIM) t = SAT_LIM;
    else if (t < -SAT_LIM) t = -SAT_LIM;
    return DATA_W'(t);
  endfunction

  // Quadrants 90..270 deg are mirrored through the origin so the residual stays within +/-90 deg.
  assign fold   = (din_phase[PHASE_W-1 -: 2] == QUAD_90) || (din_phase[PHASE_W-1 -: 2] == QUAD_180);
  assign ph_res = fold ? din_phase + PHASE_HALF : din_phase;

`ifdef MATH_POLAR2RECT_GAIN_COMP_EN
  logic [MAG_W-1:0]          mag_q, mag_d;
  logic                      neg_q, neg_d;
  logic [MAG_W+COEF_W-1:0]   prod;

  assign prod  = mag_q * INV_K;
  assign pre_x = signed'(XY_W'(prod >> (INV_K_FRAC - GUARD_BITS)));
`else
  assign pre_x = signed'(XY_W'({din_mag, {GUARD_BITS{1'b0}}}));
`endif

  math_cordic_atan_rom u_atan_rom (
    .idx_i  (iter_q),
    .atan_o (atan_val)
  );

  assign d_pos = ~z_q[Z_W-1];
  assign x_sh  = x_q >>> iter_q;
  assign y_sh  = y_q >>> iter_q;
  assign x_rot = d_pos ? x_q - y_sh : x_q + y_sh;
  assign y_rot = d_pos ? y_q + x_sh : y_q - x_sh;
  assign z_rot = d_pos ? z_q - signed'({1'b0, atan_val}) : z_q + signed'({1'b0, atan_val});

  always_comb begin
    state_d = state_q;
    iter_d  = iter_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    re_d    = re_q;
    im_d    = im_q;
    vld_d   = vld_q;
`ifdef MATH_POLAR2RECT_GAIN_COMP_EN
    mag_d   = mag_q;
    neg_d   = neg_q;
`endif
    case (state_q)
      IDLE: begin
        if (din_valid) begin
          z_d    = {ph_res[PHASE_W-1], ph_res};
          iter_d = '0;
`ifdef MATH_POLAR2RECT_GAIN_COMP_EN
          mag_d   = din_mag;
          neg_d   = fold;
          state_d = PRESCALE;
`else
          x_d     = fold ? -pre_x : pre_x;
          y_d     = '0;
          state_d = ROTATE;
`endif
        end
      end
`ifdef MATH_POLAR2RECT_GAIN_COMP_EN
      PRESCALE: begin
        x_d     = neg_q ? -pre_x : pre_x;
        y_d     = '0;
        state_d = ROTATE;
      end
`endif
      ROTATE: begin
        x_d    = x_rot;
        y_d    = y_rot;
        z_d    = z_rot;
        iter_d = iter_q + 1'b1;
        // The last iteration feeds the output registers directly, saving a cycle.
        if (iter_q == ITER_W'(CORDIC_ITER - 1)) begin
          re_d    = round_sat(x_rot);
          im_d    = round_sat(y_rot);
          vld_d   = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (dout_ready) begin
          vld_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      iter_q  <= '0;
      vld_q   <= 1'b0;
      re_q    <= '0;
      im_q    <= '0;
    end else if (ena) begin
      state_q <= state_d;
      iter_q  <= iter_d;
      vld_q   <= vld_d;
      re_q    <= re_d;
      im_q    <= im_d;
    end
  end

  always_ff @(posedge clk) begin
    if (ena) begin
      x_q <= x_d;
      y_q <= y_d;
      z_q <= z_d;
`ifdef MATH_POLAR2RECT_GAIN_COMP_EN
      mag_q <= mag_d;
      neg_q <= neg_d;
`endif
    end
  end

  assign din_ready  = (state_q == IDLE) && !rst;
  assign dout_re    = re_q;
  assign dout_im    = im_q;
  assign dout_valid = vld_q;

endmodule

// File: tb/tb_math_polar2rect_16.sv
// Self-checking bench for math_polar2rect_16 against a trigonometric reference model.
`timescale 1ns/1ps
module tb_math_polar2rect_16;

  localparam real PI = 3.14159265358979323846;
`ifdef MATH_POLAR2RECT_GAIN_COMP_EN
  localparam int  EXP_LAT = 18;
  localparam real GAIN    = 1.0;
`else
  localparam int  EXP_LAT = 17;
  localparam real GAIN    = 1.6467602581210656;
`endif

  logic               clk = 1'b0;
  logic               rst, ena, din_valid, din_ready, dout_valid, dout_ready;
  logic [16:0]        din_mag;
  logic [15:0]        din_phase;
  logic signed [15:0] dout_re, dout_im;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  math_polar2rect_16 dut (
    .clk        (clk),
    .rst        (rst),
    .ena        (ena),
    .din_mag    (din_mag),
    .din_phase  (din_phase),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .dout_re    (dout_re),
    .dout_im    (dout_im),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready)
  );

  // Ideal result: mag * gain * cos/sin(angle), rounded half-up, clipped to +/-32767.
  function automatic int model(input int mag, input int ph, input bit want_im);
    real a, v;
    int r;
    a = 2.0 * PI * real'(ph) / 65536.0;
    v = real'(mag) * GAIN * (want_im ? $sin(a) : $cos(a));
    r = $rtoi($floor(v + 0.5));
    if (r > 32767) r = 32767;
    if (r < -32767) r = -32767;
    return r;
  endfunction

  // Offers one sample, waits for the result and counts enabled edges from the accept edge.
  task automatic run_txn(input logic [16:0] mag, input logic [15:0] ph, input bit rnd, input bit leave,
                         output logic signed [15:0] re, output logic signed [15:0] im,
                         output int lat, output bit tmo);
    bit acc;
    acc = 1'b0; tmo = 1'b0; lat = 0; re = '0; im = '0;
    @(negedge clk);
    din_mag = mag; din_phase = ph; din_valid = 1'b1;
    for (int n = 0; n < 200 && !acc; n++) begin
      ena = rnd ? 1'($urandom_range(1)) : 1'b1;
      acc = ena && din_ready;
      @(posedge clk); @(negedge clk);
    end
    if (!acc) begin tmo = 1'b1; din_valid = 1'b0; return; end
    lat = 1;
    for (int n = 0; n < 400 && !dout_valid; n++) begin
      din_valid = 1'($urandom_range(1));
      din_mag   = 17'($urandom);
      din_phase = 16'($urandom);
      ena = rnd ? 1'($urandom_range(1)) : 1'b1;
      @(posedge clk);
      if (ena) lat++;
      @(negedge clk);
    end
    din_valid = 1'b0;
    if (!dout_valid) begin tmo = 1'b1; return; end
    re = dout_re; im = dout_im;
    if (!leave) begin
      for (int n = 0; n < 200 && dout_valid; n++) begin
        ena = rnd ? 1'($urandom_range(1)) : 1'b1;
        @(posedge clk); @(negedge clk);
      end
    end
    ena = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; ena = 1'b0; din_valid = 1'b1; dout_ready = 1'b1;
    din_mag = 17'd1000; din_phase = 16'h0000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", dout_valid); end
    n_cmp++; if (dout_re !== 16'sd0) begin n_fail++; $display("FAIL reset_re got %0d want 0", dout_re); end
    n_cmp++; if (dout_im !== 16'sd0) begin n_fail++; $display("FAIL reset_im got %0d want 0", dout_im); end
    n_cmp++; if (din_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b want 0", din_ready); end
    ena = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (din_ready !== 1'b0 || dout_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_over_ena got ready=%b valid=%b want 0/0", din_ready, dout_valid);
    end
    din_valid = 1'b0; ena = 1'b0;
    rst = 1'b0;
    #1;
    n_cmp++; if (din_ready !== 1'b1) begin n_fail++; $display("FAIL ready_after_reset got %b want 1", din_ready); end
    ena = 1'b1;
  endtask

  task automatic test_axes();
    logic [15:0]        phs [4];
    logic signed [15:0] re, im;
    int                 lat, er, ei;
    bit                 tmo;
    phs[0] = 16'h0000; phs[1] = 16'h4000; phs[2] = 16'h8000; phs[3] = 16'hC000;
    for (int k = 0; k < 4; k++) begin
      run_txn(17'd10000, phs[k], 1'b0, 1'b0, re, im, lat, tmo);
      n_cmp++;
      if (tmo) begin n_fail++; $display("FAIL axes_timeout ph=%h got no result want dout_valid", phs[k]); end
      else begin
        er = model(10000, int'(phs[k]), 1'b0);
        ei = model(10000, int'(phs[k]), 1'b1);
        n_cmp++; if (int'(re) - er > 2 || er - int'(re) > 2) begin
          n_fail++; $display("FAIL axes_re ph=%h got %0d want %0d+/-2", phs[k], re, er);
        end
        n_cmp++; if (int'(im) - ei > 2 || ei - int'(im) > 2) begin
          n_fail++; $display("FAIL axes_im ph=%h got %0d want %0d+/-2", phs[k], im, ei);
        end
        n_cmp++; if (lat != EXP_LAT) begin
          n_fail++; $display("FAIL axes_latency ph=%h got %0d want %0d", phs[k], lat, EXP_LAT);
        end
      end
    end
  endtask

  task automatic test_saturation();
    logic [15:0]        phs [2];
    logic signed [15:0] re, im;
    int                 lat;
    bit                 tmo;
    phs[0] = 16'h2000; phs[1] = 16'hA000;
    for (int k = 0; k < 2; k++) begin
      run_txn(17'h1FFFF, phs[k], 1'b0, 1'b0, re, im, lat, tmo);
      n_cmp++;
      if (tmo) begin n_fail++; $display("FAIL sat_timeout ph=%h got no result want dout_valid", phs[k]); end
      else begin
        n_cmp++; if (int'(re) != model(131071, int'(phs[k]), 1'b0)) begin
          n_fail++; $display("FAIL sat_re ph=%h got %0d want %0d", phs[k], re, model(131071, int'(phs[k]), 1'b0));
        end
        n_cmp++; if (int'(im) != model(131071, int'(phs[k]), 1'b1)) begin
          n_fail++; $display("FAIL sat_im ph=%h got %0d want %0d", phs[k], im, model(131071, int'(phs[k]), 1'b1));
        end
      end
    end
  endtask

  task automatic test_zero_mag();
    logic [15:0]        ph;
    logic signed [15:0] re, im;
    int                 lat;
    bit                 tmo;
    for (int k = 0; k < 4; k++) begin
      ph = 16'($urandom);
      run_txn(17'd0, ph, 1'b0, 1'b0, re, im, lat, tmo);
      n_cmp++;
      if (tmo || re !== 16'sd0 || im !== 16'sd0) begin
        n_fail++; $display("FAIL zero_mag ph=%h got (%0d,%0d) tmo=%b want (0,0)", ph, re, im, tmo);
      end
    end
  endtask

  task automatic test_backpressure();
    logic signed [15:0] re, im;
    int                 lat;
    bit                 tmo;
    dout_ready = 1'b0;
    run_txn(17'd7000, 16'h1555, 1'b0, 1'b1, re, im, lat, tmo);
    n_cmp++;
    if (tmo) begin n_fail++; $display("FAIL bp_timeout got no result want dout_valid"); end
    else begin
      n_cmp++; if (int'(re) - model(7000, 16'h1555, 1'b0) > 2 || model(7000, 16'h1555, 1'b0) - int'(re) > 2) begin
        n_fail++; $display("FAIL bp_re got %0d want %0d+/-2", re, model(7000, 16'h1555, 1'b0));
      end
      din_valid = 1'b1; din_mag = 17'd99; din_phase = 16'h7777;
      for (int k = 0; k < 5; k++) begin
        @(posedge clk); @(negedge clk);
        n_cmp++;
        if (dout_valid !== 1'b1 || dout_re !== re || dout_im !== im || din_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL bp_hold cyc=%0d got v=%b re=%0d im=%0d rdy=%b want v=1 re=%0d im=%0d rdy=0",
                   k, dout_valid, dout_re, dout_im, din_ready, re, im);
        end
      end
      dout_ready = 1'b1;
      @(posedge clk); @(negedge clk);
      din_valid = 1'b0;
      n_cmp++; if (din_ready !== 1'b1 || dout_valid !== 1'b0) begin
        n_fail++; $display("FAIL bp_release got rdy=%b v=%b want rdy=1 v=0", din_ready, dout_valid);
      end
    end
    dout_ready = 1'b1;
  endtask

  task automatic test_reset_mid();
    logic signed [15:0] re, im;
    int                 lat;
    bit                 tmo, seen;
    dout_ready = 1'b1; ena = 1'b1;
    @(negedge clk);
    din_mag = 17'd12345; din_phase = 16'h1234; din_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    din_valid = 1'b0;
    repeat (EXP_LAT - 17 + 8) @(posedge clk);
    @(negedge clk);
    rst = 1'b1; ena = 1'b0;
    @(posedge clk); @(negedge clk);
    rst = 1'b0; ena = 1'b1;
    #1;
    n_cmp++; if (din_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_ready got %b want 1", din_ready); end
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); @(negedge clk);
      if (dout_valid) seen = 1'b1;
    end
    n_cmp++; if (seen) begin n_fail++; $display("FAIL midrst_discard got dout_valid=1 want none"); end
    run_txn(17'd5000, 16'h0000, 1'b0, 1'b0, re, im, lat, tmo);
    n_cmp++;
    if (tmo || int'(re) - model(5000, 0, 1'b0) > 2 || model(5000, 0, 1'b0) - int'(re) > 2
        || int'(im) > 2 || int'(im) < -2) begin
      n_fail++; $display("FAIL midrst_next got (%0d,%0d) tmo=%b want (%0d,0)+/-2", re, im, tmo, model(5000, 0, 1'b0));
    end
  endtask

  task automatic test_back_to_back();
    int            exp_mag [$];
    int            exp_ph  [$];
    int            sent, got, cyc, last, er, ei, m, p;
    dout_ready = 1'b1; ena = 1'b1;
    sent = 0; got = 0; last = -1;
    for (cyc = 0; cyc < 400 && got < 6; cyc++) begin
      @(negedge clk);
      if (dout_valid) begin
        m = exp_mag.pop_front(); p = exp_ph.pop_front();
        er = model(m, p, 1'b0); ei = model(m, p, 1'b1);
        n_cmp++; if (int'(dout_re) - er > 2 || er - int'(dout_re) > 2 || int'(dout_im) - ei > 2 || ei - int'(dout_im) > 2) begin
          n_fail++; $display("FAIL b2b_value n=%0d got (%0d,%0d) want (%0d,%0d)+/-2", got, dout_re, dout_im, er, ei);
        end
        if (last >= 0) begin
          n_cmp++; if (cyc - last != EXP_LAT + 1) begin
            n_fail++; $display("FAIL b2b_period got %0d want %0d", cyc - last, EXP_LAT + 1);
          end
        end
        last = cyc; got++;
      end
      if (sent < 6) begin
        if (din_ready) begin
          din_mag = 17'($urandom_range(2047)); din_phase = 16'($urandom);
          exp_mag.push_back(int'(din_mag)); exp_ph.push_back(int'(din_phase));
          sent++;
        end
        din_valid = 1'b1;
      end else din_valid = 1'b0;
      @(posedge clk);
    end
    @(negedge clk);
    din_valid = 1'b0;
    n_cmp++; if (got != 6) begin n_fail++; $display("FAIL b2b_count got %0d want 6", got); end
  endtask

  task automatic test_random_sweep();
    logic [16:0]        mag;
    logic [15:0]        ph;
    logic signed [15:0] re, im;
    int                 lat, er, ei;
    bit                 tmo;
    for (int k = 0; k < 1000; k++) begin
      mag = 17'($urandom_range(2047));
      ph  = 16'($urandom);
      run_txn(mag, ph, 1'b1, 1'b0, re, im, lat, tmo);
      n_cmp++;
      if (tmo) begin n_fail++; $display("FAIL sweep_timeout mag=%0d ph=%h got no result want dout_valid", mag, ph); end
      else begin
        er = model(int'(mag), int'(ph), 1'b0);
        ei = model(int'(mag), int'(ph), 1'b1);
        n_cmp++; if (int'(re) - er > 2 || er - int'(re) > 2) begin
          n_fail++; $display("FAIL sweep_re mag=%0d ph=%h got %0d want %0d+/-2", mag, ph, re, er);
        end
        n_cmp++; if (int'(im) - ei > 2 || ei - int'(im) > 2) begin
          n_fail++; $display("FAIL sweep_im mag=%0d ph=%h got %0d want %0d+/-2", mag, ph, im, ei);
        end
        n_cmp++; if (lat != EXP_LAT) begin
          n_fail++; $display("FAIL sweep_latency mag=%0d ph=%h got %0d want %0d", mag, ph, lat, EXP_LAT);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; ena = 1'b0; din_valid = 1'b0; dout_ready = 1'b1;
    din_mag = '0; din_phase = '0;
    test_reset();
    test_axes();
    test_saturation();
    test_zero_mag();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_random_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
